// File: rtl/upload_reader.sv
// upload_reader: streams RAM bytes to the HPS during an upload session.
// The CPU is paused through a request/grant handshake before any RAM access.
// If the grant is lost mid-fetch, the fetch is retried from the latched address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no session; waiting for an upload rise with a matching index
// S_HOLD  | pause requested, waiting for mem_grant; HPS is held off
// S_READY | RAM port owned; accepting ioctl_rd
// S_FETCH | RAM read in flight; counting down the read latency
// S_END   | session over; done pulses for this cycle
module upload_reader #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [7:0]  INDEX       = 8'd5,
  parameter int unsigned SIZE        = 17'h10000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_READY = 3'd2,
    S_FETCH = 3'd3,
    S_END   = 3'd4
  } state_t;

  localparam logic [24:0] SIZE_A = 25'(SIZE);
  localparam logic [1:0]  LAT    = 2'(RAM_LATENCY);

  state_t            state_q, state_d;
  logic              upload_q, upload_d;
  logic              pending_q, pending_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              pause_q, pause_d;
  logic              done_q, done_d;
  logic              in_range;

  assign in_range = (ioctl_addr < SIZE_A);

  // Next-state and registered-output computation; session end has top priority.
  always_comb begin
    state_d    = state_q;
    upload_d   = ioctl_upload;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    din_d      = din_q;
    wait_d     = wait_q;
    pause_d    = pause_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ioctl_upload && !upload_q && (ioctl_index == INDEX)) begin
          state_d   = S_HOLD;
          pause_d   = 1'b1;
          wait_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
      S_HOLD, S_READY, S_FETCH: begin
        if (!ioctl_upload) begin
          state_d   = S_END;
          pause_d   = 1'b0;
          wait_d    = 1'b0;
          done_d    = 1'b1;
          pending_d = 1'b0;
        end else if (state_q == S_HOLD) begin
          if (mem_grant) begin
            if (pending_q) begin
              state_d   = S_FETCH;
              mem_rd_d  = 1'b1;
              cnt_d     = LAT;
              pending_d = 1'b0;
            end else begin
              state_d = S_READY;
              wait_d  = 1'b0;
            end
          end
        end else if (!mem_grant) begin
          // Grant lost: park in HOLD; an accepted or in-flight read is retried later.
          state_d = S_HOLD;
          wait_d  = 1'b1;
          if (state_q == S_FETCH) begin
            pending_d = 1'b1;
          end else if (ioctl_rd) begin
            if (in_range) begin
              mem_addr_d = ioctl_addr[ADDR_W-1:0];
              pending_d  = 1'b1;
            end else begin
              din_d = 8'h00;
            end
          end
        end else if (state_q == S_READY) begin
          if (ioctl_rd) begin
            if (in_range) begin
              mem_addr_d = ioctl_addr[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              wait_d     = 1'b1;
              cnt_d      = LAT;
              state_d    = S_FETCH;
            end else begin
              din_d = 8'h00;
            end
          end
        end else begin
          if (cnt_q == 2'd0) begin
            din_d   = mem_q;
            wait_d  = 1'b0;
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      upload_q   <= 1'b0;
      pending_q  <= 1'b0;
      cnt_q      <= 2'd0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      pause_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      upload_q   <= upload_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      pause_q    <= pause_d;
      done_q     <= done_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign done       = done_q;

endmodule

// File: tb/tb_upload_reader.sv
// tb_upload_reader: two instances (RAM latency 1 and 3) share the HPS-side stimulus.
module tb_upload_reader;
  localparam int SIZE = 32'h10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_upload, ioctl_rd, mem_grant;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  din1, din3, q1, q3;
  logic        wait1, wait3, pause1, pause3, rd1, rd3, done1, done3;
  logic [16:0] maddr1, maddr3;

  logic [7:0] ram [0:131071];
  logic [7:0] p1 = 8'h00, p3a = 8'h00, p3b = 8'h00, p3c = 8'h00;

  int total = 0, bad = 0;
  int nrd1 = 0, nrd3 = 0, ndone = 0, npause = 0;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  upload_reader #(.ADDR_W(17), .RAM_LATENCY(1), .INDEX(8'd5), .SIZE(17'h10000)) dut1 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(wait1),
    .pause_req(pause1), .mem_grant(mem_grant), .mem_addr(maddr1), .mem_rd(rd1),
    .mem_q(q1), .done(done1));

  upload_reader #(.ADDR_W(17), .RAM_LATENCY(3), .INDEX(8'd5), .SIZE(17'h10000)) dut3 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din3), .ioctl_wait(wait3),
    .pause_req(pause3), .mem_grant(mem_grant), .mem_addr(maddr3), .mem_rd(rd3),
    .mem_q(q3), .done(done3));

  // RAM models: data is valid only for the one cycle after the nominal latency.
  always @(posedge clk) begin
    p1  <= rd1 ? ram[maddr1] : 8'hEE;
    p3a <= rd3 ? ram[maddr3] : 8'hEE;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign q1 = p1;
  assign q3 = p3c;

  always @(negedge clk) begin
    if (rd1) nrd1++;
    if (rd3) nrd3++;
    if (done1 || done3) ndone++;
    if (pause1 || pause3) npause++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [24:0] a);
    return (a < SIZE) ? ram[a[16:0]] : 8'h00;
  endfunction

  // Called just after the edge that raised mem_rd; checks both instances' landing times.
  task automatic finish_fetch(input logic [7:0] e);
    tick();
    chk("rd_pulse_len", {rd3, rd1}, 2'b00);
    chk("wait_busy", {wait3, wait1}, 2'b11);
    tick();
    chk("din_lat1", din1, e);
    chk("wait_lat1", wait1, 1'b0);
    chk("wait_lat3_busy", wait3, 1'b1);
    tick();
    tick();
    chk("din_lat3", din3, e);
    chk("wait_lat3", wait3, 1'b0);
    chk("din_lat1_hold", din1, e);
  endtask

  task automatic read_check(input logic [24:0] a, input logic [7:0] e);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    if (a < SIZE) begin
      chk("mem_rd", {rd3, rd1}, 2'b11);
      chk("mem_addr", {maddr3, maddr1}, {a[16:0], a[16:0]});
      finish_fetch(e);
    end else begin
      chk("oor_no_rd", {rd3, rd1}, 2'b00);
      chk("oor_din", {din3, din1}, 16'h0000);
      chk("oor_wait", {wait3, wait1}, 2'b00);
    end
  endtask

  task automatic start_session();
    ioctl_index = 8'd5;
    ioctl_upload = 1'b1;
    tick();
    tick();
    chk("session_ready", {pause3, pause1, wait3, wait1}, 4'b1100);
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    tick();
    chk("end_done", {done3, done1, pause3, pause1, wait3, wait1}, 6'b110000);
    tick();
    chk("end_done_fall", {done3, done1}, 2'b00);
  endtask

  initial begin
    int n0, d0, q0;
    logic [24:0] base, a;

    for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
    ram[17'h00010] = 8'hA5;
    ram[17'h00020] = 8'h3C;
    ram[17'h0FFFF] = 8'h5A;
    ram[17'h00000] = 8'h11;
    ram[17'h01234] = 8'hC7;
    vecs[0] = '{25'h0000010, 8'hA5};
    vecs[1] = '{25'h0010000, 8'h00};
    vecs[2] = '{25'h0000020, 8'h3C};
    vecs[3] = '{25'h1FFFFFF, 8'h00};
    vecs[4] = '{25'h000FFFF, 8'h5A};
    vecs[5] = '{25'h0000000, 8'h11};
    vecs[6] = '{25'h0001234, 8'hC7};
    vecs[7] = '{25'h0010001, 8'h00};

    reset = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    mem_grant = 1'b0;
    #12;
    chk("reset_data", {din3, din1, maddr3, maddr1}, 64'h0);
    chk("reset_ctl", {wait3, wait1, pause3, pause1, rd3, rd1, done3, done1}, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Grant withheld for 20 cycles.
    n0 = nrd1 + nrd3;
    ioctl_index = 8'd5;
    ioctl_upload = 1'b1;
    tick();
    tick();
    chk("hold_pause", {pause3, pause1, wait3, wait1}, 4'b1111);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_wait", {pause3, pause1, wait3, wait1}, 4'b1111);
    end
    chk("hold_no_rd", nrd1 + nrd3, n0);
    mem_grant = 1'b1;
    tick();
    chk("grant_wait_fall", {pause3, pause1, wait3, wait1}, 4'b1100);

    // Directed table.
    for (int i = 0; i < 8; i++) read_check(vecs[i].addr, vecs[i].exp);

    // Randomized: sequential stream of 256, then scattered addresses.
    base = 25'($urandom_range(0, SIZE - 257));
    for (int k = 0; k < 256; k++) read_check(base + 25'(k), model(base + 25'(k)));
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) a = 25'($urandom);
      else a = 25'($urandom_range(0, 32'h1FFFF));
      repeat ($urandom_range(0, 2)) tick();
      read_check(a, model(a));
    end

    // Grant loss mid-fetch, then retry of the same address.
    read_check(25'h10, 8'hA5);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h20;
    tick();
    ioctl_rd = 1'b0;
    chk("gl_rd", {rd3, rd1}, 2'b11);
    mem_grant = 1'b0;
    tick();
    chk("gl_hold", {pause3, pause1, wait3, wait1}, 4'b1111);
    chk("gl_din_kept", {din3, din1}, 16'hA5A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gl_hold_wait", {wait3, wait1, rd3, rd1}, 4'b1100);
    end
    chk("gl_din_kept2", {din3, din1}, 16'hA5A5);
    mem_grant = 1'b1;
    tick();
    chk("gl_rerd", {rd3, rd1}, 2'b11);
    chk("gl_readdr", {maddr3, maddr1}, {17'h20, 17'h20});
    finish_fetch(8'h3C);
    end_session();

    // Abort during FETCH.
    start_session();
    read_check(25'h20, 8'h3C);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h10;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    chk("abort_end", {done3, done1, pause3, pause1, wait3, wait1}, 6'b110000);
    chk("abort_din", {din3, din1}, 16'h3C3C);
    tick();
    chk("abort_done_fall", {done3, done1}, 2'b00);
    tick();
    tick();
    tick();
    chk("abort_din_kept", {din3, din1}, 16'h3C3C);

    // Upload fall coincident with ioctl_rd.
    start_session();
    n0 = nrd1 + nrd3;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h10;
    ioctl_upload = 1'b0;
    tick();
    ioctl_rd = 1'b0;
    chk("coinc_done", {done3, done1, rd3, rd1}, 4'b1100);
    tick();
    tick();
    chk("coinc_no_rd", nrd1 + nrd3, n0);

    // Reset in READY.
    start_session();
    read_check(25'h20, 8'h3C);
    d0 = ndone;
    #2;
    reset = 1'b1;
    ioctl_upload = 1'b0;
    #1;
    chk("rst_mid_data", {din3, din1, maddr3, maddr1}, 64'h0);
    chk("rst_mid_ctl", {wait3, wait1, pause3, pause1, rd3, rd1, done3, done1}, 8'h00);
    repeat (4) tick();
    chk("rst_no_done", ndone, d0);
    reset = 1'b0;
    tick();

    // Foreign index session.
    d0 = ndone;
    q0 = npause;
    n0 = nrd1 + nrd3;
    ioctl_index = 8'd3;
    ioctl_upload = 1'b1;
    repeat (3) tick();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h10;
    tick();
    ioctl_rd = 1'b0;
    repeat (6) tick();
    ioctl_upload = 1'b0;
    repeat (3) tick();
    chk("idx_no_pause", npause, q0);
    chk("idx_no_done", ndone, d0);
    chk("idx_no_rd", nrd1 + nrd3, n0);
    chk("idx_wait", {wait3, wait1}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/upload_reader.md
# upload_reader

Services HPS upload (read-back) sessions by streaming bytes out of a core-side synchronous RAM onto `ioctl_din`; it is the reverse path of the ROM/BIOS download into `system`. It sits in `emu` between `hps_io` (`ioctl_upload`, `ioctl_rd`, `ioctl_addr`, `ioctl_din`, `ioctl_wait`) and one RAM read port. Before any RAM access it requests a CPU pause through the pause system and waits for a grant.

## Interface
Parameters:
- `ADDR_W`, 17: RAM byte-address width.
- `RAM_LATENCY`, 1: read latency of the RAM in cycles, legal range 1..3.
- `INDEX`, 8'd5: the `ioctl_index` value that selects this uploader.
- `SIZE`, 17'h10000: number of valid bytes in the region.

Ports:
- `clk_sys` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_upload` in 1: upload session active (level).
- `ioctl_index` in 8: session index.
- `ioctl_rd` in 1: one-cycle byte request.
- `ioctl_addr` in 25: byte address of the request, valid while `ioctl_rd` is high.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: HPS must not issue `ioctl_rd` while this is high.
- `pause_req` out 1: asks the core to halt the CPU.
- `mem_grant` in 1: the CPU is halted and the RAM port is free.
- `mem_addr` out ADDR_W: RAM read address.
- `mem_rd` out 1: one-cycle RAM read strobe.
- `mem_q` in 8: RAM read data.
- `done` out 1: one-cycle pulse when a session ends.

## Operation
- States are IDLE, HOLD, READY, FETCH and END.
- IDLE:
  - On the `ioctl_upload` rising edge with `ioctl_index`==INDEX, go to HOLD.
  - An index mismatch is ignored for the whole session.
- HOLD:
  - `pause_req`=1 and `ioctl_wait`=1.
  - When `mem_grant`=1, go to READY, or to FETCH if a request is pending.
- READY:
  - `pause_req`=1 and `ioctl_wait`=0.
  - On `ioctl_rd` with `ioctl_addr`<SIZE: latch `mem_addr`=`ioctl_addr[ADDR_W-1:0]`, pulse `mem_rd`, set `ioctl_wait`=1, load the latency counter, go to FETCH.
  - On `ioctl_rd` with `ioctl_addr`>=SIZE: `ioctl_din`<=8'h00 at the next edge, no `mem_rd`, stay in READY. `ioctl_wait` stays 0.
- FETCH:
  - The counter decrements each cycle. On expiry, capture `mem_q` into `ioctl_din`, drop `ioctl_wait`, go to READY.
  - An `ioctl_rd` arriving in FETCH is a protocol violation and is ignored.
- `mem_grant` falling in READY or FETCH:
  - Go to HOLD with `ioctl_wait`=1.
  - An in-flight fetch is abandoned and marked pending. On re-grant the same `mem_addr` is re-read: `mem_rd` pulses again and the counter reloads.
- `ioctl_upload` falling in HOLD, READY or FETCH:
  - Go to END.
  - Any pending or in-flight fetch is discarded and `ioctl_din` keeps its last value.
- END:
  - `pause_req`=0, `ioctl_wait`=0, `done`=1 for one cycle, then IDLE.
- Simultaneous `ioctl_upload` fall and `ioctl_rd`: the session end wins and no `mem_rd` is issued.
- A new session can start no earlier than the cycle after END.

## Timing
- Reset values: state IDLE; `ioctl_din`=0, `ioctl_wait`=0, `pause_req`=0, `mem_addr`=0, `mem_rd`=0, `done`=0. Reset mid-session aborts immediately and does not pulse `done`.
- All outputs are registered.
- Latency, taking edge E as the edge where `ioctl_rd` is sampled high in READY:
  - `mem_rd` is high for the cycle after E.
  - `mem_q` is sampled at edge E+1+RAM_LATENCY.
  - `ioctl_din` updates and `ioctl_wait` falls at that same edge.
  - Read-to-data latency is therefore RAM_LATENCY+1 cycles.
- `pause_req` rises one edge after the `ioctl_upload` rise is detected.
- READY is entered one edge after `mem_grant` is sampled high.
- `done` is high exactly one cycle after END is entered and falls on the next edge.

## Test plan
- Basic read: RAM holds 8'hA5 at 17'h00010, RAM_LATENCY=1, INDEX=5. Start a session and hold `mem_grant`=1. Pulse `ioctl_rd` with addr 0x10 -> `mem_rd` for 1 cycle with `mem_addr`=0x10; `ioctl_din`=8'hA5 and `ioctl_wait`=0 exactly 2 cycles after the sampling edge.
- Latency sweep: repeat the basic read with RAM_LATENCY=3 -> data lands 4 cycles after the sampling edge. Stream 256 sequential reads -> every returned byte matches RAM contents.
- Grant handshake: `mem_grant` held 0 for 20 cycles after the session starts -> `pause_req`=1 and `ioctl_wait`=1 throughout, no `mem_rd`. Raise the grant -> `ioctl_wait` falls 1 cycle later.
- Out of range: read addr 0x10000 with SIZE=0x10000 -> no `mem_rd`; `ioctl_din`=8'h00 at the next edge.
- Grant loss mid-fetch: drop `mem_grant` the cycle after `mem_rd` for addr 0x20 (data 8'h3C) -> state HOLD with `ioctl_wait`=1. Re-grant -> a second `mem_rd` to 0x20 and `ioctl_din`=8'h3C.
- Abort and reset: drop `ioctl_upload` during FETCH -> no `ioctl_din` update, `pause_req`=0, one-cycle `done`. Assert `reset` mid-READY -> all outputs 0 asynchronously and no `done`. A session with `ioctl_index`=3 -> `pause_req` never asserts.
